uart_tx_fifo: RTL

- Byte-oriented UART transmitter (8N1, or 8E1 with the optional feature) with a small FIFO on its input.
- Serialises bytes onto the tx_o line; this is the host-bound serial line that ends up on UART_RXD_OUT at board level.
- Drives the line the board's RX pin samples, complementing the SoC's receive path.
- Sits between a bus-side producer (debug module or CPU peripheral) and the pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, data width and a helper
// that derives the baud divider from clock and baud rates.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // PARITY is always part of the encoding so that both builds share one type.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous circular-buffer FIFO with a separate occupancy counter.
// Writes while full and reads while empty are ignored; the read port shows the
// head entry combinationally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: written on accepted writes only.
  // NOTE: the array has no reset; contents are don't-care until written, and
  // leaving it out lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks fill.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-oriented UART transmitter (8N1/8N2) fed by a small input FIFO.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd via parity_odd_i)
// between the data bits and the stop bit(s).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic                          tx_req_i,
  input  logic [7:0]                    tx_data_i,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd_i,
`endif
  output logic                          tx_ack_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic [7:0]  fifo_head;
  logic        fifo_empty;
  logic        pop;
  logic        step;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  // A full FIFO refuses the write even if a pop happens in the same cycle.
  assign tx_ack_o = tx_req_i & ~fifo_full_o;
  assign busy_o   = (state != IDLE) | ~fifo_empty;
  assign bit_end  = (baud_cnt == 16'(BAUD_DIV - 1));

  uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .wr_en   (tx_ack_o),
    .wr_data (tx_data_i),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full_o),
    .empty   (fifo_empty),
    .count   (fifo_cnt_o)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; pop loads a new byte, step advances to the next bit
  // within DATA or STOP without leaving the state.
  // NOTE: every output gets a default first so no path through the case leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            step = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            // Back-to-back frames: go straight to START with no idle gap.
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter, bit index and shift register; the counter restarts on
  // every state or bit change and is held at zero while idle.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE || state_nxt != state || step) baud_cnt <= '0;
      else                                              baud_cnt <= baud_cnt + 16'd1;

      if (state_nxt != state) bit_idx <= '0;
      else if (step)          bit_idx <= bit_idx + 3'd1;

      if (pop) begin
        shift_q  <= fifo_head;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^fifo_head;
`endif
      end else if (step && state == DATA) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

  // Registered line driver; follows the FSM one cycle later, idles high.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tx_o <= 1'b1;
    end else begin
      case (state)
        START:   tx_o <= 1'b0;
        DATA:    tx_o <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx_o <= parity_q ^ parity_odd_i;
`endif
        default: tx_o <= 1'b1;
      endcase
    end
  end

endmodule
